// File: rtl/rf_write_arbiter_if.sv
// Requester, reservation, scoreboard-query and register-file write signals
// shared between the writeback arbiter and the pipeline around it.
interface rf_write_arbiter_if #(
  parameter int DBITS = 32
) ();
  logic             a_valid;
  logic [3:0]       a_dest;
  logic [DBITS-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [3:0]       b_dest;
  logic [DBITS-1:0] b_data;
  logic             b_ready;
  logic             rsv_valid;
  logic [3:0]       rsv_dest;
  logic [3:0]       src0;
  logic [3:0]       src1;
  logic             src0_busy;
  logic             src1_busy;
  logic [15:0]      busy;
  logic             rf_we;
  logic [3:0]       rf_dest;
  logic [DBITS-1:0] rf_data;
  logic             init_done;

  modport master (
    output a_valid, a_dest, a_data, b_valid, b_dest, b_data,
           rsv_valid, rsv_dest, src0, src1,
    input  a_ready, b_ready, src0_busy, src1_busy, busy,
           rf_we, rf_dest, rf_data, init_done
  );

  modport slave (
    input  a_valid, a_dest, a_data, b_valid, b_dest, b_data,
           rsv_valid, rsv_dest, src0, src1,
    output a_ready, b_ready, src0_busy, src1_busy, busy,
           rf_we, rf_dest, rf_data, init_done
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write arbiter with round-robin grant, a
// pending-write scoreboard and an optional post-reset zero-fill sweep.
module rf_write_arbiter #(
  parameter int DBITS     = 32,
  parameter int INIT_ZERO = 1
) (
  input  logic                clk,
  input  logic                reset,
  rf_write_arbiter_if.slave   bus
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       init_cnt;
  logic             last_grant_b;
  logic [15:0]      busy_q;
  logic [15:0]      set_mask;
  logic [15:0]      clr_mask;
  logic             a_ready;
  logic             b_ready;
  logic             xfer;
  logic             rf_we;
  logic [3:0]       rf_dest;
  logic [DBITS-1:0] rf_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
      init_cnt     <= 4'd0;
      last_grant_b <= 1'b1;
      busy_q       <= 16'd0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT)
        init_cnt <= init_cnt + 4'd1;
      if (xfer)
        last_grant_b <= b_ready;
      // A reservation landing on the register being written wins.
      busy_q <= (busy_q & ~clr_mask) | set_mask;
    end
  end

  always_comb begin
    state_nxt = state;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    xfer      = 1'b0;
    rf_we     = 1'b0;
    rf_dest   = 4'd0;
    rf_data   = '0;
    set_mask  = 16'd0;
    clr_mask  = 16'd0;
    case (state)
      ST_INIT: begin
        rf_we   = 1'b1;
        rf_dest = init_cnt;
        if (init_cnt == 4'd15)
          state_nxt = ST_RUN;
      end
      default: begin
        // On a conflict, the requester not granted last time goes first.
        a_ready = bus.a_valid & (~bus.b_valid | last_grant_b);
        b_ready = bus.b_valid & (~bus.a_valid | ~last_grant_b);
        xfer    = a_ready | b_ready;
        rf_we   = xfer;
        if (a_ready) begin
          rf_dest = bus.a_dest;
          rf_data = bus.a_data;
        end else if (b_ready) begin
          rf_dest = bus.b_dest;
          rf_data = bus.b_data;
        end
        if (xfer)
          clr_mask[rf_dest] = 1'b1;
        if (bus.rsv_valid)
          set_mask[bus.rsv_dest] = 1'b1;
      end
    endcase
  end

  assign bus.a_ready   = a_ready;
  assign bus.b_ready   = b_ready;
  assign bus.rf_we     = rf_we;
  assign bus.rf_dest   = rf_dest;
  assign bus.rf_data   = rf_data;
  assign bus.busy      = busy_q;
  assign bus.src0_busy = busy_q[bus.src0];
  assign bus.src1_busy = busy_q[bus.src1];
  assign bus.init_done = (state == ST_RUN);

endmodule
